tile_match_controller: RTL and testbench

Game sequencer for the 16-tile colour-matching board. It accepts tile selections from the cursor/input logic and reads both chosen tiles' colours from the tile RAM through one RAM port. It holds the pair visible for a reveal interval, then either clears both tiles to the matched colour or flips them back, and tracks pairs found, moves made and game completion. It sits between the input front-end and port A of the tile RAM; the display logic consumes its first/second tile outputs.

---
 rtl/tile_match_controller_pkg.sv | 8 +
 rtl/tile_match_controller_if.sv | 13 +
 rtl/tile_match_controller_reveal_timer.sv | 18 +
 rtl/tile_match_controller.sv | 144 ++++++++++++++
 tb/tb_tile_match_controller.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tile_match_controller_pkg.sv
// tile_pkg: shared board constants and sequencer state encoding for the tile matcher
package tile_pkg;
  localparam int NUM_TILES = 16;
  localparam int ADDR_W = $clog2(NUM_TILES);
  localparam int COLOR_W = 8;
  localparam logic [COLOR_W-1:0] DEFAULT_MATCHED_COLOR = 8'h00;
  typedef enum logic [3:0] {IDLE, RD1, CHK1, WAIT2, RD2, CHK2, SHOW, CLR1, CLR2, DONE} tileState;
endpackage

// File: rtl/tile_match_controller_if.sv
// tile_match_controller_if: selection handshake plus tile RAM port A
interface tile_match_controller_if;
  import tile_pkg::*;
  logic sel_valid;
  logic sel_ready;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [COLOR_W-1:0] ram_wdata;
  logic [COLOR_W-1:0] ram_rdata;
  modport master (output sel_valid, sel_addr, ram_rdata, input sel_ready, ram_addr, ram_we, ram_wdata);
  modport slave (input sel_valid, sel_addr, ram_rdata, output sel_ready, ram_addr, ram_we, ram_wdata);
endinterface

// File: rtl/tile_match_controller_reveal_timer.sv
// reveal_timer: loadable down-counter; expired flags the last cycle of the interval
module reveal_timer #(
  parameter int REVEAL_CYCLES = 25_000_000,
  localparam int W = $clog2(REVEAL_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) count <= '0;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - W'(1);
  assign expired = count == W'(1);
endmodule

// File: rtl/tile_match_controller.sv
// tile_match_controller: pair-selection sequencer for the 16-tile matching game
// Reads both tiles through one RAM port, reveals, then clears or flips them back.
module tile_match_controller
  import tile_pkg::*;
#(
  parameter int REVEAL_CYCLES = 25_000_000,
  parameter int NUM_PAIRS = 8,
  parameter logic [COLOR_W-1:0] MATCHED_COLOR = DEFAULT_MATCHED_COLOR
) (
  input  logic                     clk,
  input  logic                     resetn,
  tile_match_controller_if.slave   bus,
  output logic [ADDR_W-1:0]        first_addr,
  output logic                     first_valid,
  output logic [ADDR_W-1:0]        second_addr,
  output logic                     second_valid,
  output logic                     match_pulse,
  output logic                     mismatch_pulse,
  output logic                     reject_pulse,
  output logic [3:0]               match_count,
  output logic [7:0]               move_count,
  output logic                     game_done
);
  localparam int TW = $clog2(REVEAL_CYCLES + 1);
  tileState state;
  logic [COLOR_W-1:0] colorFirst, colorSecond;
  logic accept, tileCleared, timerLoad, timerExpired;
  assign accept = bus.sel_valid && bus.sel_ready;
  assign tileCleared = bus.ram_rdata == MATCHED_COLOR;
  assign timerLoad = state == CHK2 && !tileCleared;
  reveal_timer #(.REVEAL_CYCLES(REVEAL_CYCLES)) timer (
    .clk(clk),
    .resetn(resetn),
    .load(timerLoad),
    .load_value(TW'(REVEAL_CYCLES)),
    .expired(timerExpired)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      bus.sel_ready <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_wdata <= '0;
      first_addr <= '0;
      first_valid <= 1'b0;
      second_addr <= '0;
      second_valid <= 1'b0;
      match_pulse <= 1'b0;
      mismatch_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      match_count <= '0;
      move_count <= '0;
      game_done <= 1'b0;
      colorFirst <= '0;
      colorSecond <= '0;
    end else begin
      match_pulse <= 1'b0;
      mismatch_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      // sel_ready is registered, so it is set on every transition into IDLE/WAIT2
      case (state)
        IDLE: begin
          bus.sel_ready <= 1'b1;
          if (accept) begin
            bus.ram_addr <= bus.sel_addr;
            first_addr <= bus.sel_addr;
            bus.sel_ready <= 1'b0;
            state <= RD1;
          end
        end
        RD1: state <= CHK1;
        CHK1: begin
          bus.sel_ready <= 1'b1;
          if (tileCleared) begin
            reject_pulse <= 1'b1;
            state <= IDLE;
          end else begin
            colorFirst <= bus.ram_rdata;
            first_valid <= 1'b1;
            state <= WAIT2;
          end
        end
        WAIT2:
          if (accept) begin
            if (bus.sel_addr == first_addr) reject_pulse <= 1'b1;
            else begin
              bus.ram_addr <= bus.sel_addr;
              second_addr <= bus.sel_addr;
              bus.sel_ready <= 1'b0;
              state <= RD2;
            end
          end
        RD2: state <= CHK2;
        CHK2:
          if (tileCleared) begin
            reject_pulse <= 1'b1;
            bus.sel_ready <= 1'b1;
            state <= WAIT2;
          end else begin
            colorSecond <= bus.ram_rdata;
            second_valid <= 1'b1;
            move_count <= move_count + 8'(move_count != 8'hFF);
            state <= SHOW;
          end
        SHOW:
          if (timerExpired) begin
            if (colorFirst == colorSecond) begin
              bus.ram_addr <= first_addr;
              bus.ram_we <= 1'b1;
              bus.ram_wdata <= MATCHED_COLOR;
              state <= CLR1;
            end else begin
              mismatch_pulse <= 1'b1;
              first_valid <= 1'b0;
              second_valid <= 1'b0;
              bus.sel_ready <= 1'b1;
              state <= IDLE;
            end
          end
        CLR1: begin
          bus.ram_addr <= second_addr;
          state <= CLR2;
        end
        CLR2: begin
          bus.ram_we <= 1'b0;
          bus.ram_wdata <= '0;
          match_pulse <= 1'b1;
          match_count <= match_count + 4'd1;
          first_valid <= 1'b0;
          second_valid <= 1'b0;
          if (match_count + 4'd1 == 4'(NUM_PAIRS)) begin
            game_done <= 1'b1;
            state <= DONE;
          end else begin
            bus.sel_ready <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tile_match_controller.sv
// tb_tile_match_controller: scoreboard bench with a behavioural tile RAM on port A
module tb_tile_match_controller;
  import tile_pkg::*;
  localparam logic [2:0] EV_MATCH = 3'b100, EV_MISMATCH = 3'b010, EV_REJECT = 3'b001;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  tile_match_controller_if bus();
  logic [3:0] first_addr, second_addr, match_count;
  logic first_valid, second_valid, match_pulse, mismatch_pulse, reject_pulse, game_done;
  logic [7:0] move_count;
  tile_match_controller #(.REVEAL_CYCLES(4), .NUM_PAIRS(8), .MATCHED_COLOR(8'h00)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .first_addr(first_addr),
    .first_valid(first_valid),
    .second_addr(second_addr),
    .second_valid(second_valid),
    .match_pulse(match_pulse),
    .mismatch_pulse(mismatch_pulse),
    .reject_pulse(reject_pulse),
    .match_count(match_count),
    .move_count(move_count),
    .game_done(game_done)
  );
  logic [7:0] initColors [16] = '{8'h3C, 8'hC8, 8'hE0, 8'hE0, 8'h3C, 8'hC8, 8'h11, 8'h11,
                                   8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55, 8'h55};
  logic [7:0] tbRam [16];
  logic [7:0] shadow [16];
  logic [2:0] expQ [$];
  int nChecks = 0, nErrors = 0, writes = 0, cyc = 0, showCyc = 0, expMoves = 0, expMatches = 0;
  logic mFirstValid = 1'b0;
  logic [3:0] mFirst = '0;
  logic prevSv = 1'b0;
  logic [2:0] ev;
  logic [2:0] evExp;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.sel_ready, bus.ram_addr, bus.ram_we, bus.ram_wdata, first_addr, first_valid,
                second_addr, second_valid, match_pulse, mismatch_pulse, reject_pulse,
                match_count, move_count, game_done});
  endfunction
  // Synchronous RAM: read data appears the cycle after the address is sampled
  always @(posedge clk) begin
    cyc++;
    if (bus.ram_we) begin
      tbRam[bus.ram_addr] <= bus.ram_wdata;
      writes++;
    end
    bus.ram_rdata <= tbRam[bus.ram_addr];
  end
  always @(negedge clk) begin
    if (second_valid && !prevSv) showCyc = cyc;
    prevSv = second_valid;
    ev = {match_pulse, mismatch_pulse, reject_pulse};
    if (ev != 3'b000) begin
      if (expQ.size() == 0) check("sb_extra", 64'(ev), 64'(0));
      else begin
        evExp = expQ.pop_front();
        check("sb_event", 64'(ev), 64'(evExp));
      end
      if (ev == EV_MATCH) check("match_lat", 64'(cyc - showCyc), 64'(6));
      if (ev == EV_MISMATCH) check("mismatch_lat", 64'(cyc - showCyc), 64'(4));
    end
  end
  task automatic select(input logic [3:0] a);
    int n = 0;
    @(negedge clk);
    bus.sel_valid = 1'b1;
    bus.sel_addr = a;
    while (!bus.sel_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("sel_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1 bus.sel_valid = 1'b0;
  endtask
  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!(bus.sel_ready || game_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("settle_timeout", 64'(n), 64'(0));
  endtask
  task automatic pick(input logic [3:0] a);
    if (!mFirstValid) begin
      if (shadow[a] == 8'h00) expQ.push_back(EV_REJECT);
      else begin
        mFirstValid = 1'b1;
        mFirst = a;
      end
    end else if (a == mFirst || shadow[a] == 8'h00) expQ.push_back(EV_REJECT);
    else begin
      expMoves = expMoves < 255 ? expMoves + 1 : 255;
      if (shadow[a] == shadow[mFirst]) begin
        expQ.push_back(EV_MATCH);
        shadow[a] = 8'h00;
        shadow[mFirst] = 8'h00;
        expMatches++;
      end else expQ.push_back(EV_MISMATCH);
      mFirstValid = 1'b0;
    end
    select(a);
    settle();
  endtask
  task automatic modelReset();
    mFirstValid = 1'b0;
    expMoves = 0;
    expMatches = 0;
  endtask
  int w;
  int pa [8] = '{0, 1, 2, 6, 8, 10, 12, 14};
  int pb [8] = '{4, 5, 3, 7, 9, 11, 13, 15};
  initial begin
    bus.sel_valid = 1'b0;
    bus.sel_addr = '0;
    foreach (tbRam[i]) begin
      tbRam[i] = initColors[i];
      shadow[i] = initColors[i];
    end
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'(0));
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 64'(bus.sel_ready), 64'(1));
    pick(4'd2);
    pick(4'd3);
    check("ram2_cleared", 64'(tbRam[2]), 64'(0));
    check("ram3_cleared", 64'(tbRam[3]), 64'(0));
    check("match_count1", 64'(match_count), 64'(1));
    check("move_count1", 64'(move_count), 64'(1));
    check("writes_match", 64'(writes), 64'(2));
    pick(4'd0);
    pick(4'd1);
    check("writes_mismatch", 64'(writes), 64'(2));
    check("valids_clear", 64'({first_valid, second_valid}), 64'(0));
    check("match_count_keep", 64'(match_count), 64'(expMatches));
    check("move_count2", 64'(move_count), 64'(expMoves));
    pick(4'd5);
    pick(4'd5);
    check("wait2_hold", 64'({bus.sel_ready, first_valid, first_addr}), 64'({1'b1, 1'b1, 4'd5}));
    pick(4'd2);
    check("reveal_kept", 64'({first_valid, second_valid, first_addr}), 64'({1'b1, 1'b0, 4'd5}));
    pick(4'd1);
    pick(4'd3);
    check("idle_reject", 64'(first_valid), 64'(0));
    check("match_count2", 64'(match_count), 64'(expMatches));
    for (int i = 0; i < 300; i++) begin
      pick(4'd0);
      pick(4'd6);
    end
    check("move_sat", 64'(move_count), 64'(255));
    check("move_model", 64'(move_count), 64'(expMoves));
    pick(4'd6);
    select(4'd7);
    for (int n = 0; n < 50 && !second_valid; n++) @(negedge clk);
    check("show_reached", 64'(second_valid), 64'(1));
    repeat (2) @(negedge clk);
    w = writes;
    resetn = 1'b0;
    #1 check("rst_show_outs", outs(), 64'(0));
    repeat (3) @(negedge clk);
    check("rst_show_nowrite", 64'(writes), 64'(w));
    check("rst_show_ram7", 64'(tbRam[7]), 64'(8'h11));
    resetn = 1'b1;
    modelReset();
    pick(4'd6);
    select(4'd7);
    for (int n = 0; n < 50 && !bus.ram_we; n++) @(negedge clk);
    check("clr1_reached", 64'(bus.ram_we), 64'(1));
    w = writes;
    resetn = 1'b0;
    #1 check("rst_clr1_outs", outs(), 64'(0));
    repeat (3) @(negedge clk);
    check("rst_clr1_nowrite", 64'(writes), 64'(w));
    check("rst_clr1_ram6", 64'(tbRam[6]), 64'(8'h11));
    resetn = 1'b1;
    modelReset();
    foreach (tbRam[i]) begin
      tbRam[i] = initColors[i];
      shadow[i] = initColors[i];
    end
    for (int i = 0; i < 8; i++) begin
      pick(4'(pa[i]));
      pick(4'(pb[i]));
    end
    check("game_done", 64'({game_done, bus.sel_ready}), 64'({1'b1, 1'b0}));
    check("final_matches", 64'(match_count), 64'(8));
    check("final_moves", 64'(move_count), 64'(expMoves));
    w = writes;
    @(negedge clk);
    bus.sel_valid = 1'b1;
    bus.sel_addr = 4'd8;
    repeat (20) @(negedge clk);
    bus.sel_valid = 1'b0;
    check("done_no_write", 64'(writes), 64'(w));
    check("done_hold", 64'({game_done, bus.sel_ready, first_valid}), 64'(3'b100));
    check("sb_drained", 64'(expQ.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", nErrors);
    $fatal(1);
  end
endmodule
